fp_decode_dp_pipeline: RTL and testbench

- Converts a 65-bit recoded double-precision value back to a 64-bit IEEE-754 double.
- It is the inverse of the FPU's DP recode pipeline and feeds FP store data and FP-to-integer register moves.
- It is a STAGES-deep pipeline with a valid/ready handshake and full backpressure.
- Every accepted operand emerges exactly once, in order.

---
 rtl/fp_decode_dp_pipeline.sv | 118 +++++++++++
 tb/tb_fp_decode_dp_pipeline.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_decode_dp_pipeline.sv
// Recoded double-precision (65-bit) to IEEE-754 double converter.
// Combinational decode feeds a STAGES-deep valid/ready pipeline with full backpressure.
module fp_decode_dp_pipeline #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned EXP_W  = 11,
  parameter int unsigned SIG_W  = 53,
  parameter int unsigned EXC_W  = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+SIG_W:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+SIG_W-1:0] result,
  output logic [EXC_W-1:0]       exc
);

  localparam int unsigned FracW = SIG_W - 1;
  localparam int unsigned RexpW = EXP_W + 1;
  localparam int unsigned DataW = 1 + EXP_W + FracW;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic             sign;
  logic [RexpW-1:0] rexp;
  logic [FracW-1:0] rsig;
  logic [2:0]       cls;
  logic [EXP_W-1:0] norm_exp;
  logic [RexpW-1:0] sub_shift;
  logic [FracW-1:0] sub_frac;
  logic [EXP_W-1:0] dec_exp;
  logic [FracW-1:0] dec_frac;
  logic [DataW-1:0] dec_data;

  assign sign      = in_data[EXP_W+SIG_W];
  assign rexp      = in_data[EXP_W+SIG_W-1 -: RexpW];
  assign rsig      = in_data[FracW-1:0];
  assign cls       = rexp[RexpW-1 -: 3];
  // Only the low exponent bits matter: normals stay below 2048 after unbiasing.
  assign norm_exp  = rexp[EXP_W-1:0] - 11'd1025;
  assign sub_shift = 12'd1026 - rexp;
  assign sub_frac  = FracW'({1'b1, rsig} >> sub_shift);

  always_comb begin
    dec_exp  = '0;
    dec_frac = '0;
    if (cls == 3'b000) begin
      dec_exp  = '0;
      dec_frac = '0;
    end else if (rexp[RexpW-1 -: 2] == 2'b11) begin
      dec_exp = '1;
      if (rexp[RexpW-3]) begin
        dec_frac = rsig;
      end
    end else if (rexp >= 12'd1026) begin
      dec_exp  = norm_exp;
      dec_frac = rsig;
    end else if (rexp >= 12'd974) begin
      dec_frac = sub_frac;
    end
  end

  // Out-of-range encodings fall through with exp=frac=0, i.e. a signed zero.
  assign dec_data = {sign, dec_exp, dec_frac};

  // ---------------------------------------------------------------------------
  // Pipeline
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] valid_q;
  logic [DataW-1:0]  data_q [STAGES];
  logic [STAGES:0]   load;
  logic [STAGES-1:0] adv;

  // load[STAGES] stands for the consumer; readiness ripples back to the input.
  always_comb begin
    load         = '0;
    adv          = '0;
    load[STAGES] = out_ready;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      adv[i]  = valid_q[i] & load[i+1];
      load[i] = ~valid_q[i] | adv[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      if (load[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          data_q[0] <= dec_data;
        end
      end
      for (int i = 1; i < int'(STAGES); i++) begin
        if (load[i]) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) begin
            data_q[i] <= data_q[i-1];
          end
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = valid_q[STAGES-1];
  assign result    = data_q[STAGES-1];
  // Recoded-to-IEEE conversion is exact, so no flag can ever be raised.
  assign exc       = '0;

endmodule

// File: tb/tb_fp_decode_dp_pipeline.sv
// Bench for fp_decode_dp_pipeline: directed checks on a STAGES=2 instance, random
// valid/ready traffic on STAGES=1 and STAGES=4 instances, all scored against a reference model.
module tb_fp_decode_dp_pipeline;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode written directly from the encoding rules with integer arithmetic.
  function automatic logic [63:0] ref_decode(input logic [64:0] x);
    logic        s;
    int unsigned e;
    logic [63:0] sig;
    logic [10:0] ee;
    s   = x[64];
    e   = int'(x[63:52]);
    sig = {12'h0, x[51:0]};
    if (e < 512) return {s, 63'b0};
    if (e >= 3584) return {s, 11'h7FF, x[51:0]};
    if (e >= 3072) return {s, 11'h7FF, 52'b0};
    if (e >= 1026) begin
      ee = 11'(e - 1025);
      return {s, ee, x[51:0]};
    end
    if (e >= 974) begin
      sig = (sig | (64'd1 << 52)) >> (1026 - e);
      return {s, 11'b0, sig[51:0]};
    end
    return {s, 63'b0};
  endfunction

  // kind: 0 zero, 1 inf, 2 nan, 3 subnormal, 4 out-of-range, 5 normal, other = any class
  function automatic logic [64:0] gen_op(input int kind);
    logic [63:0] r;
    logic [11:0] e;
    int          k;
    r = {$urandom, $urandom};
    k = (kind < 0 || kind > 5) ? int'($urandom_range(0, 9)) : kind;
    case (k)
      0:       e = 12'($urandom_range(0, 511));
      1:       e = 12'($urandom_range(3072, 3583));
      2:       e = 12'($urandom_range(3584, 4095));
      3:       e = 12'($urandom_range(974, 1025));
      4:       e = 12'($urandom_range(512, 973));
      default: e = 12'($urandom_range(1026, 3071));
    endcase
    return {r[63], e, r[51:0]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned ST = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [64:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic [4:0]  exc;
    logic        done;
    logic        lat_chk;
    logic [63:0] exp_q[$];
    int          cyc_q[$];

    fp_decode_dp_pipeline #(.STAGES(ST)) u_dut (
      .clk      (clk),
      .reset    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .exc      (exc)
    );

    // Scoreboard: transfers are judged at the negedge before the edge that performs them.
    initial begin
      logic        held_v;
      logic [63:0] held_r;
      int          t_in;
      held_v = 1'b0;
      held_r = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          exp_q.delete();
          cyc_q.delete();
          held_v = 1'b0;
          check($sformatf("s%0d_reset_valid", ST), 64'(out_valid), 64'd0);
          check($sformatf("s%0d_reset_result", ST), result, 64'd0);
        end else begin
          if (held_v) begin
            check($sformatf("s%0d_hold_valid", ST), 64'(out_valid), 64'd1);
            check($sformatf("s%0d_hold_result", ST), result, held_r);
          end
          if (out_valid) check($sformatf("s%0d_exc", ST), 64'(exc), 64'd0);
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              compared++;
              mismatched++;
              $display("FAIL s%0d_spurious: got %h expected no output", ST, result);
            end else begin
              check($sformatf("s%0d_result", ST), result, exp_q.pop_front());
              t_in = cyc_q.pop_front();
              if (lat_chk) check($sformatf("s%0d_latency", ST), 64'(cyc - t_in), 64'(ST));
            end
          end
          if (in_valid && in_ready) begin
            exp_q.push_back(ref_decode(in_data));
            cyc_q.push_back(cyc);
          end
          held_v = out_valid && !out_ready;
          held_r = result;
        end
      end
    end

    if (g == 0) begin : g_dir
      task automatic send_one(input string name, input logic [64:0] op, input logic [63:0] lit);
        int n;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = op;
        @(negedge clk);
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        check({name, "_latency"}, 64'(n), 64'(ST));
        check(name, result, lit);
      endtask

      initial begin
        logic [64:0] ops  [8];
        logic [63:0] lits [8];
        logic        took;
        int          acc;
        done      = 1'b0;
        lat_chk   = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 64'(in_ready), 64'd1);

        ops[0] = {1'b0, 12'h800, 52'h0};             lits[0] = 64'h3FF0000000000000;
        ops[1] = {1'b1, 12'hC00, 52'h0};             lits[1] = 64'hFFF0000000000000;
        ops[2] = {1'b0, 12'hE00, 52'h8000000000000}; lits[2] = 64'h7FF8000000000000;
        ops[3] = {1'b1, 12'h000, 52'h123};           lits[3] = 64'h8000000000000000;
        ops[4] = {1'b0, 12'd974, 52'h0};             lits[4] = 64'h0000000000000001;
        ops[5] = {1'b0, 12'd1025, 52'h0};            lits[5] = 64'h0008000000000000;
        ops[6] = {1'b0, 12'd1026, 52'h0};            lits[6] = 64'h0010000000000000;
        ops[7] = {1'b0, 12'd973, 52'h5};             lits[7] = 64'h0000000000000000;
        for (int i = 0; i < 8; i++) begin
          check($sformatf("model_pin%0d", i), ref_decode(ops[i]), lits[i]);
          send_one($sformatf("directed%0d", i), ops[i], lits[i]);
        end

        // Streaming: back-to-back normals with exact-latency checking.
        repeat (3) @(posedge clk);
        lat_chk = 1'b1;
        for (int i = 0; i < 20; i++) begin
          @(posedge clk);
          #1;
          in_valid = 1'b1;
          in_data  = gen_op(5);
          @(negedge clk);
          check("stream_in_ready", 64'(in_ready), 64'd1);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (ST + 2) @(posedge clk);
        lat_chk = 1'b0;
        check("stream_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure: exactly ST accepted while the output is stalled.
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = gen_op(-1);
        acc       = 0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          took = in_ready;
          if (took) acc++;
          @(posedge clk);
          #1;
          if (took) in_data = gen_op(-1);
        end
        check("bp_accepted", 64'(acc), 64'(ST));
        @(negedge clk);
        check("bp_full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          took = in_ready;
          @(posedge clk);
          #1;
          if (took) in_data = gen_op(-1);
        end
        in_valid = 1'b0;
        repeat (ST + 2) @(posedge clk);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Reset with two operands in flight.
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = gen_op(5);
        @(posedge clk);
        #1 in_data = gen_op(5);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_valid", 64'(out_valid), 64'd0);
        check("async_reset_result", result, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        in_data = gen_op(-1);
        send_one("after_reset", in_data, ref_decode(in_data));
        repeat (ST + 2) @(posedge clk);
        check("final_drained", 64'(exp_q.size()), 64'd0);
        done = 1'b1;
      end
    end else begin : g_rnd
      initial begin
        logic took;
        int   n_acc;
        int   guard;
        done      = 1'b0;
        lat_chk   = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        took      = 1'b0;
        n_acc     = 0;
        guard     = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        while (n_acc < 10000 && guard < 60000) begin
          @(posedge clk);
          #1;
          if (took || !in_valid) begin
            in_valid = ($urandom_range(0, 99) < 70);
            in_data  = gen_op(-1);
          end
          out_ready = ($urandom_range(0, 99) < 70);
          @(negedge clk);
          took = in_valid && in_ready;
          if (took) n_acc++;
          guard++;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (ST + 3) @(posedge clk);
        check($sformatf("s%0d_all_accepted", ST), 64'(n_acc), 64'd10000);
        check($sformatf("s%0d_drained", ST), 64'(exp_q.size()), 64'd0);
        done = 1'b1;
      end
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(g_inst[0].done === 1'b1 && g_inst[1].done === 1'b1 && g_inst[2].done === 1'b1)
           && t < 90000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 90000) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: got %0d cycles expected completion before 90000", t);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
